// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the sum(1..LIMIT) sequencer and its datapath.
// Register-file roles: R1 loop index, R2 running sum, R3 constant 1, R4 limit.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5
    } alu_op_e;

    localparam logic [2:0] R_ZERO = 3'd0;
    localparam logic [2:0] R_I    = 3'd1;
    localparam logic [2:0] R_SUM  = 3'd2;
    localparam logic [2:0] R_ONE  = 3'd3;
    localparam logic [2:0] R_LIM  = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ONE   = 4'd1,
        ST_CLR_I = 4'd2,
        ST_CLR_S = 4'd3,
        ST_CLR_L = 4'd4,
        ST_LIM   = 4'd5,
        ST_INC   = 4'd6,
        ST_CMP   = 4'd7,
        ST_ACC   = 4'd8,
        ST_OUT   = 4'd9,
        ST_DONE  = 4'd10
    } state_e;

endpackage

// File: rtl/dp_ctrl_fsm.sv
// Moore controller sequencing the 8-bit RF/ALU datapath to compute sum(1..LIMIT) mod 256.
// Optional DP_CTRL_STEP_EN adds a step input that gates state advance and side-effect strobes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// ONE    | R3 <= 1
// CLR_I  | R1 <= 0
// CLR_S  | R2 <= 0
// CLR_L  | R4 <= 0
// LIM    | R4 <= R4 + 1, repeated LIMIT times to build the bound in the RF
// INC    | R1 <= R1 + 1
// CMP    | ALU computes R4 - R1; iLe10 reports 1 <= i <= LIMIT
// ACC    | R2 <= R2 + R1
// OUT    | output register loads R2
// DONE   | one-cycle done pulse, back to IDLE
module dp_ctrl_fsm
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef DP_CTRL_STEP_EN
    input  logic       step,
`endif
    input  logic       iLe10,
    output logic       RFSrcMuxSel,
    output logic [2:0] aluOp,
    output logic [2:0] readAddr1,
    output logic [2:0] readAddr2,
    output logic [2:0] writeAddr,
    output logic       writeEn,
    output logic       outBuf,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] S_IDLE  = ST_IDLE;
    localparam logic [3:0] S_ONE   = ST_ONE;
    localparam logic [3:0] S_CLR_I = ST_CLR_I;
    localparam logic [3:0] S_CLR_S = ST_CLR_S;
    localparam logic [3:0] S_CLR_L = ST_CLR_L;
    localparam logic [3:0] S_LIM   = ST_LIM;
    localparam logic [3:0] S_INC   = ST_INC;
    localparam logic [3:0] S_CMP   = ST_CMP;
    localparam logic [3:0] S_ACC   = ST_ACC;
    localparam logic [3:0] S_OUT   = ST_OUT;
    localparam logic [3:0] S_DONE  = ST_DONE;

    // Only meaningful when LIMIT > 0; the LIM state is bypassed otherwise.
    localparam logic [7:0] LIM_LAST = 8'(LIMIT - 1);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [7:0] lim_cnt;
    logic       step_en;
    logic       advance;
    logic       we_raw;
    logic       ob_raw;
    logic       done_raw;

`ifdef DP_CTRL_STEP_EN
    assign step_en = step;
`else
    assign step_en = 1'b1;
`endif

    // IDLE keeps watching start every cycle even when stepping is throttled.
    assign advance = step_en | (state == S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ONE;
            S_ONE:   state_nxt = S_CLR_I;
            S_CLR_I: state_nxt = S_CLR_S;
            S_CLR_S: state_nxt = S_CLR_L;
            S_CLR_L: state_nxt = (LIMIT > 0) ? S_LIM : S_INC;
            S_LIM:   if (lim_cnt == LIM_LAST) state_nxt = S_INC;
            S_INC:   state_nxt = S_CMP;
            S_CMP:   state_nxt = iLe10 ? S_ACC : S_DONE;
            S_ACC:   state_nxt = S_OUT;
            S_OUT:   state_nxt = S_INC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            lim_cnt <= 8'd0;
        end else if (advance) begin
            state <= state_nxt;
            if (state == S_LIM) begin
                lim_cnt <= (state_nxt == S_LIM) ? lim_cnt + 8'd1 : 8'd0;
            end
        end
    end

    always_comb begin
        RFSrcMuxSel = 1'b0;
        aluOp       = ALU_ADD;
        readAddr1   = R_ZERO;
        readAddr2   = R_ZERO;
        writeAddr   = R_ZERO;
        we_raw      = 1'b0;
        ob_raw      = 1'b0;
        done_raw    = 1'b0;
        case (state)
            S_ONE: begin
                RFSrcMuxSel = 1'b1;
                writeAddr   = R_ONE;
                we_raw      = 1'b1;
            end
            S_CLR_I: begin
                writeAddr = R_I;
                we_raw    = 1'b1;
            end
            S_CLR_S: begin
                writeAddr = R_SUM;
                we_raw    = 1'b1;
            end
            S_CLR_L: begin
                writeAddr = R_LIM;
                we_raw    = 1'b1;
            end
            S_LIM: begin
                readAddr1 = R_LIM;
                readAddr2 = R_ONE;
                writeAddr = R_LIM;
                we_raw    = 1'b1;
            end
            S_INC: begin
                readAddr1 = R_I;
                readAddr2 = R_ONE;
                writeAddr = R_I;
                we_raw    = 1'b1;
            end
            S_CMP: begin
                readAddr1 = R_LIM;
                readAddr2 = R_I;
                aluOp     = ALU_SUB;
            end
            S_ACC: begin
                readAddr1 = R_SUM;
                readAddr2 = R_I;
                writeAddr = R_SUM;
                we_raw    = 1'b1;
            end
            S_OUT: begin
                readAddr1 = R_SUM;
                ob_raw    = 1'b1;
            end
            S_DONE: done_raw = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign writeEn = we_raw & step_en;
    assign outBuf  = ob_raw & step_en;
    assign done    = done_raw & step_en;

endmodule
